// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared state encoding for the interrupt controller
package irq_ctrl_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQUEST = ST_REQUEST,
    SERVICE = ST_SERVICE
  } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
module irq_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches, masks and arbitrates NUM_IRQ sources onto a single core request,
// holding the vector stable from request through acknowledge until end-of-interrupt.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                   NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = {NUM_IRQ{1'b1}},
  parameter logic [NUM_IRQ-1:0]   MASK_RESET = {NUM_IRQ{1'b1}},
  parameter int                   NUM_WIDTH  = 16
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic [NUM_IRQ-1:0]   I_irq,
  input  logic                 I_mask_we,
  input  logic [NUM_IRQ-1:0]   I_mask_data,
  input  logic                 I_ack,
  input  logic                 I_eoi,
  output logic                 O_irq_active,
  output logic [NUM_WIDTH-1:0] O_irq_number,
  output logic [NUM_IRQ-1:0]   O_mask,
  output logic [NUM_IRQ-1:0]   O_pending,
  output logic                 O_in_service
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  state_t state;
  logic [NUM_IRQ-1:0] irq_q, eligible, edge_set, ack_clr;
  logic [IW-1:0] sel, idx;
  logic valid, take_ack;
  assign take_ack = state == REQUEST && I_ack;
  assign eligible = O_pending & O_mask;
  assign edge_set = I_irq & ~irq_q;
  // only edge channels are consumed by acknowledge; a fresh edge in the same cycle survives
  assign ack_clr = take_ack ? EDGE_MASK & (NUM_IRQ'(1) << sel) : '0;
  assign O_irq_number = NUM_WIDTH'(sel);
  irq_prio_enc #(.N(NUM_IRQ), .W(IW)) u_enc (.req(eligible), .valid(valid), .idx(idx));
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state <= IDLE;
      irq_q <= '0;
      O_pending <= '0;
      O_mask <= MASK_RESET;
      sel <= '0;
      O_irq_active <= 1'b0;
      O_in_service <= 1'b0;
    end else begin
      irq_q <= I_irq;
      O_pending <= (EDGE_MASK & ((O_pending & ~ack_clr) | edge_set)) | (~EDGE_MASK & I_irq);
      if (I_mask_we) O_mask <= I_mask_data;
      case (state)
        IDLE: if (valid) begin
          sel <= idx;
          O_irq_active <= 1'b1;
          state <= REQUEST;
        end
        REQUEST: if (I_ack) begin
          O_irq_active <= 1'b0;
          O_in_service <= 1'b1;
          state <= SERVICE;
        end
        SERVICE: if (I_eoi) begin
          O_in_service <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed checks of irq_ctrl with channel 7 configured as level-triggered
module tb_irq_ctrl;
  logic        I_clk, I_reset, I_mask_we, I_ack, I_eoi;
  logic [7:0]  I_irq, I_mask_data, O_mask, O_pending;
  logic        O_irq_active, O_in_service;
  logic [15:0] O_irq_number;
  int n_checks = 0;
  int n_fail = 0;

  irq_ctrl #(.NUM_IRQ(8), .EDGE_MASK(8'h7F), .MASK_RESET(8'hFF), .NUM_WIDTH(16)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_irq(I_irq), .I_mask_we(I_mask_we),
    .I_mask_data(I_mask_data), .I_ack(I_ack), .I_eoi(I_eoi),
    .O_irq_active(O_irq_active), .O_irq_number(O_irq_number), .O_mask(O_mask),
    .O_pending(O_pending), .O_in_service(O_in_service)
  );

  initial I_clk = 0;
  always #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic pulse_irq(input int ch);
    I_irq[ch] = 1'b1;
    tick();
    I_irq[ch] = 1'b0;
  endtask

  task automatic serve();
    I_ack = 1;
    tick();
    I_ack = 0;
    I_eoi = 1;
    tick();
    I_eoi = 0;
  endtask

  task automatic test_reset();
    I_reset = 1; I_irq = '0; I_mask_we = 0; I_mask_data = '0; I_ack = 0; I_eoi = 0;
    repeat (2) tick();
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", O_irq_active); end
    n_checks++; if (O_irq_number !== 16'd0) begin n_fail++; $display("FAIL reset_number: got %0d want 0", O_irq_number); end
    n_checks++; if (O_pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", O_pending); end
    n_checks++; if (O_in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service: got %b want 0", O_in_service); end
    n_checks++; if (O_mask !== 8'hFF) begin n_fail++; $display("FAIL reset_mask: got %h want ff", O_mask); end
    I_reset = 0;
    tick();
  endtask

  task automatic test_basic_edge();
    pulse_irq(3);
    n_checks++; if (O_pending !== 8'h08) begin n_fail++; $display("FAIL basic_pending: got %h want 08", O_pending); end
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet: got %b want 0", O_irq_active); end
    tick();
    n_checks++; if (O_irq_active !== 1'b1) begin n_fail++; $display("FAIL basic_active: got %b want 1", O_irq_active); end
    n_checks++; if (O_irq_number !== 16'd3) begin n_fail++; $display("FAIL basic_number: got %0d want 3", O_irq_number); end
    I_ack = 1;
    tick();
    I_ack = 0;
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL basic_ack_active: got %b want 0", O_irq_active); end
    n_checks++; if (O_pending[3] !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pending: got %b want 0", O_pending[3]); end
    n_checks++; if (O_in_service !== 1'b1) begin n_fail++; $display("FAIL basic_in_service: got %b want 1", O_in_service); end
    n_checks++; if (O_irq_number !== 16'd3) begin n_fail++; $display("FAIL basic_number_hold: got %0d want 3", O_irq_number); end
    I_eoi = 1;
    tick();
    I_eoi = 0;
    n_checks++; if (O_in_service !== 1'b0) begin n_fail++; $display("FAIL basic_eoi: got %b want 0", O_in_service); end
    repeat (2) tick();
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL basic_no_rerequest: got %b want 0", O_irq_active); end
  endtask

  task automatic test_priority();
    I_irq[5] = 1; I_irq[2] = 1;
    tick();
    I_irq[5] = 0; I_irq[2] = 0;
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd2) begin n_fail++; $display("FAIL prio_first: got active=%b num=%0d want 1/2", O_irq_active, O_irq_number); end
    serve();
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %b want 0", O_irq_active); end
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd5) begin n_fail++; $display("FAIL prio_second: got active=%b num=%0d want 1/5", O_irq_active, O_irq_number); end
    serve();
  endtask

  task automatic test_lock();
    pulse_irq(4);
    tick();
    n_checks++; if (O_irq_number !== 16'd4) begin n_fail++; $display("FAIL lock_sel: got %0d want 4", O_irq_number); end
    pulse_irq(0);
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd4) begin n_fail++; $display("FAIL lock_hold: got active=%b num=%0d want 1/4", O_irq_active, O_irq_number); end
    I_ack = 1;
    tick();
    I_ack = 0;
    n_checks++; if (O_irq_number !== 16'd4) begin n_fail++; $display("FAIL lock_after_ack: got %0d want 4", O_irq_number); end
    I_eoi = 1;
    tick();
    I_eoi = 0;
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd0) begin n_fail++; $display("FAIL lock_next: got active=%b num=%0d want 1/0", O_irq_active, O_irq_number); end
    serve();
  endtask

  task automatic test_mask();
    I_mask_we = 1; I_mask_data = 8'hFE;
    tick();
    I_mask_we = 0;
    n_checks++; if (O_mask !== 8'hFE) begin n_fail++; $display("FAIL mask_write: got %h want fe", O_mask); end
    pulse_irq(0);
    tick();
    n_checks++; if (O_pending[0] !== 1'b1) begin n_fail++; $display("FAIL mask_pending: got %b want 1", O_pending[0]); end
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL mask_blocked: got %b want 0", O_irq_active); end
    I_mask_we = 1; I_mask_data = 8'hFF;
    tick();
    I_mask_we = 0;
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd0) begin n_fail++; $display("FAIL mask_release: got active=%b num=%0d want 1/0", O_irq_active, O_irq_number); end
    serve();
  endtask

  task automatic test_level();
    I_irq[7] = 1;
    repeat (2) tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd7) begin n_fail++; $display("FAIL level_req: got active=%b num=%0d want 1/7", O_irq_active, O_irq_number); end
    I_ack = 1;
    tick();
    I_ack = 0;
    n_checks++; if (O_pending[7] !== 1'b1) begin n_fail++; $display("FAIL level_ack_keeps: got %b want 1", O_pending[7]); end
    I_eoi = 1;
    tick();
    I_eoi = 0;
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd7) begin n_fail++; $display("FAIL level_rereq: got active=%b num=%0d want 1/7", O_irq_active, O_irq_number); end
    I_ack = 1;
    tick();
    I_ack = 0;
    I_irq[7] = 0;
    I_eoi = 1;
    tick();
    I_eoi = 0;
    tick();
    n_checks++; if (O_irq_active !== 1'b0) begin n_fail++; $display("FAIL level_dropped: got %b want 0", O_irq_active); end
    n_checks++; if (O_pending !== 8'h00) begin n_fail++; $display("FAIL level_pending_clear: got %h want 00", O_pending); end
  endtask

  task automatic test_boundaries();
    I_eoi = 1;
    tick();
    I_eoi = 0;
    I_ack = 1;
    tick();
    I_ack = 0;
    tick();
    n_checks++; if (O_in_service !== 1'b0 || O_irq_active !== 1'b0) begin n_fail++; $display("FAIL idle_strobes: got svc=%b act=%b want 0/0", O_in_service, O_irq_active); end
    pulse_irq(3);
    tick();
    I_irq[3] = 1; I_ack = 1;
    tick();
    I_irq[3] = 0; I_ack = 0;
    n_checks++; if (O_pending[3] !== 1'b1 || O_in_service !== 1'b1) begin n_fail++; $display("FAIL set_wins: got pend=%b svc=%b want 1/1", O_pending[3], O_in_service); end
    I_eoi = 1;
    tick();
    I_eoi = 0;
    tick();
    n_checks++; if (O_irq_active !== 1'b1 || O_irq_number !== 16'd3) begin n_fail++; $display("FAIL set_wins_rereq: got active=%b num=%0d want 1/3", O_irq_active, O_irq_number); end
    serve();
    pulse_irq(1);
    tick();
    I_ack = 1; I_mask_we = 1; I_mask_data = 8'h0F;
    tick();
    I_ack = 0; I_mask_we = 0;
    pulse_irq(6);
    n_checks++; if (O_in_service !== 1'b1 || O_mask !== 8'h0F || O_pending[6] !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got svc=%b mask=%h pend=%h want 1/0f/x1xxxxxx", O_in_service, O_mask, O_pending); end
    #2 I_reset = 1;
    #1;
    n_checks++; if (O_irq_active !== 1'b0 || O_irq_number !== 16'd0 || O_in_service !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl: got act=%b num=%0d svc=%b want 0/0/0", O_irq_active, O_irq_number, O_in_service); end
    n_checks++; if (O_pending !== 8'h00 || O_mask !== 8'hFF) begin n_fail++; $display("FAIL async_reset_regs: got pend=%h mask=%h want 00/ff", O_pending, O_mask); end
    tick();
    I_reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_edge();
    test_priority();
    test_lock();
    test_mask();
    test_level();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
